// File: rtl/tlc5941_rx_model_pkg.sv
// Shared constants and channel-slice helpers for the TLC5941 receive model.
// Greyscale frames pack 16 x 12-bit channels, channel 15 MSB first on the wire;
// dot-correction frames pack 16 x 6-bit channels into the low 96 bits.
package tlc5941_rx_model_pkg;

    localparam int NUM_CH     = 16;
    localparam int GS_BITS    = 12;
    localparam int DC_BITS    = 6;
    localparam int SHIFT_BITS = NUM_CH * GS_BITS;
    localparam int GS_CNT_W   = 13;
    localparam logic [GS_CNT_W-1:0] GS_CNT_MAX = 13'd4096;

    // LSB position of channel ch inside a GS-packed shift register.
    function automatic int gs_lsb(input int ch);
        return ch * GS_BITS;
    endfunction

    // LSB position of channel ch inside a DC-packed shift register.
    function automatic int dc_lsb(input int ch);
        return ch * DC_BITS;
    endfunction

endpackage

// File: rtl/tlc5941_rx_model_sync_edge.sv
// N-stage synchronizer with single-cycle edge strobes.
// Ports:
//   clock, reset  - system clock, async active-high reset
//   async_in      - signal from another clock domain
//   level         - synchronized level
//   rise, fall    - one-cycle pulses on synchronized edges
// Resets low so a low input produces no edge after reset release.
module tlc5941_rx_model_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tlc5941_rx_model.sv
// Receiving end of a TLC5941 serial LED-driver link, bit-exact model.
// Ports:
//   clock, reset        - system clock, async active-high reset
//   sclk, sin           - serial clock/data (async), data MSB first
//   xlat, mode          - latch strobe (rising edge), 0 = GS frame, 1 = DC frame
//   blank, gsclk        - output blank / PWM counter clear, PWM reference clock
//   sout                - shift register MSB for daisy chaining
//   pwm_out[15:0]       - per-channel on/off, registered
//   rd_ch, rd_gs, rd_dc - combinational readback of latched channel values
//   latched, count_err  - one-cycle pulses per accepted xlat
// latched acts as a valid strobe with no ready: each accepted xlat produces
// exactly one latched cycle, and count_err is only meaningful in that cycle.
module tlc5941_rx_model
    import tlc5941_rx_model_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int GS_FRAME_BITS = 192,
    parameter int DC_FRAME_BITS = 96
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sclk,
    input  logic         sin,
    input  logic         xlat,
    input  logic         mode,
    input  logic         blank,
    input  logic         gsclk,
    output logic         sout,
    output logic [15:0]  pwm_out,
    input  logic [3:0]   rd_ch,
    output logic [11:0]  rd_gs,
    output logic [5:0]   rd_dc,
    output logic         latched,
    output logic         count_err
);

    logic sclk_rise, sin_s, xlat_rise, mode_s, blank_s, gsclk_rise;
    logic sclk_lvl_unused, xlat_lvl_unused, gsclk_lvl_unused;
    logic sin_rise_unused, mode_rise_unused, blank_rise_unused;
    logic [5:0] fall_unused;

    // Equal depth on every input keeps sin aligned with the sclk edge.
    tlc5941_rx_model_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock(clock), .reset(reset), .async_in(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(fall_unused[0]));
    tlc5941_rx_model_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sin (
        .clock(clock), .reset(reset), .async_in(sin),
        .level(sin_s), .rise(sin_rise_unused), .fall(fall_unused[1]));
    tlc5941_rx_model_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_xlat (
        .clock(clock), .reset(reset), .async_in(xlat),
        .level(xlat_lvl_unused), .rise(xlat_rise), .fall(fall_unused[2]));
    tlc5941_rx_model_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
        .clock(clock), .reset(reset), .async_in(mode),
        .level(mode_s), .rise(mode_rise_unused), .fall(fall_unused[3]));
    tlc5941_rx_model_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_blank (
        .clock(clock), .reset(reset), .async_in(blank),
        .level(blank_s), .rise(blank_rise_unused), .fall(fall_unused[4]));
    tlc5941_rx_model_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_gsclk (
        .clock(clock), .reset(reset), .async_in(gsclk),
        .level(gsclk_lvl_unused), .rise(gsclk_rise), .fall(fall_unused[5]));

    logic [SHIFT_BITS-1:0] shift_q, shift_d;
    logic [7:0]            bit_cnt_q, bit_cnt_d;
    logic [GS_BITS-1:0]    gs_q [NUM_CH];
    logic [GS_BITS-1:0]    gs_d [NUM_CH];
    logic [DC_BITS-1:0]    dc_q [NUM_CH];
    logic [DC_BITS-1:0]    dc_d [NUM_CH];
    logic [GS_CNT_W-1:0]   gs_cnt_q, gs_cnt_d;
    logic [NUM_CH-1:0]     pwm_q, pwm_d;
    logic                  latched_q, latched_d;
    logic                  count_err_q, count_err_d;

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gs_d        = gs_q;
        dc_d        = dc_q;
        gs_cnt_d    = gs_cnt_q;
        pwm_d       = '0;
        latched_d   = 1'b0;
        count_err_d = 1'b0;

        if (sclk_rise) begin
            shift_d = {shift_q[SHIFT_BITS-2:0], sin_s};
            if (bit_cnt_q != 8'hFF) begin
                bit_cnt_d = bit_cnt_q + 8'd1;
            end
        end

        // Latch sees the post-shift register and count when both edges coincide.
        if (xlat_rise) begin
            latched_d = 1'b1;
            if (mode_s) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    dc_d[n] = shift_d[dc_lsb(n) +: DC_BITS];
                end
                count_err_d = (bit_cnt_d != 8'(DC_FRAME_BITS));
            end else begin
                for (int n = 0; n < NUM_CH; n++) begin
                    gs_d[n] = shift_d[gs_lsb(n) +: GS_BITS];
                end
                count_err_d = (bit_cnt_d != 8'(GS_FRAME_BITS));
            end
            bit_cnt_d = 8'd0;
        end

        if (blank_s) begin
            gs_cnt_d = '0;
        end else if (gsclk_rise && (gs_cnt_q != GS_CNT_MAX)) begin
            gs_cnt_d = gs_cnt_q + 13'd1;
        end

        // Compare against the current count; the output lags a count change by one cycle.
        for (int n = 0; n < NUM_CH; n++) begin
            pwm_d[n] = ~blank_s & (gs_cnt_q < {1'b0, gs_q[n]});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gs_q        <= '{default: '0};
            dc_q        <= '{default: '0};
            gs_cnt_q    <= '0;
            pwm_q       <= '0;
            latched_q   <= 1'b0;
            count_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gs_q        <= gs_d;
            dc_q        <= dc_d;
            gs_cnt_q    <= gs_cnt_d;
            pwm_q       <= pwm_d;
            latched_q   <= latched_d;
            count_err_q <= count_err_d;
        end
    end

    assign sout      = shift_q[SHIFT_BITS-1];
    assign pwm_out   = pwm_q;
    assign rd_gs     = gs_q[rd_ch];
    assign rd_dc     = dc_q[rd_ch];
    assign latched   = latched_q;
    assign count_err = count_err_q;

endmodule

// File: tb/tb_tlc5941_rx_model.sv
module tb_tlc5941_rx_model;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0, sin = 1'b0, xlat = 1'b0, mode = 1'b0, blank = 1'b1, gsclk = 1'b0;
    logic [3:0] rd_ch = 4'd0;

    logic        sout0, sout1;
    logic [15:0] pwm0, pwm1;
    logic [11:0] rd_gs0, rd_gs1;
    logic [5:0]  rd_dc0, rd_dc1;
    logic        latched0, latched1, count_err0, count_err1;

    int tests = 0;
    int fails = 0;

    logic [0:0] exp_q0[$];
    logic [0:0] exp_q1[$];

    tlc5941_rx_model u0 (
        .clock(clock), .reset(reset), .sclk(sclk), .sin(sin), .xlat(xlat),
        .mode(mode), .blank(blank), .gsclk(gsclk), .sout(sout0), .pwm_out(pwm0),
        .rd_ch(rd_ch), .rd_gs(rd_gs0), .rd_dc(rd_dc0), .latched(latched0),
        .count_err(count_err0));

    tlc5941_rx_model u1 (
        .clock(clock), .reset(reset), .sclk(sclk), .sin(sout0), .xlat(xlat),
        .mode(mode), .blank(blank), .gsclk(gsclk), .sout(sout1), .pwm_out(pwm1),
        .rd_ch(rd_ch), .rd_gs(rd_gs1), .rd_dc(rd_dc1), .latched(latched1),
        .count_err(count_err1));

    // clock / reset
    always #5 clock = ~clock;

    // monitor: pops an expected count_err for every latched pulse
    always @(negedge clock) begin
        if (!reset) begin
            if (latched0) begin
                tests++;
                if (exp_q0.size() == 0) begin
                    fails++;
                    $display("FAIL u0_latched_unexpected: latched=1 count_err=%0b, no latch expected", count_err0);
                end else begin
                    logic [0:0] e;
                    e = exp_q0.pop_front();
                    if (count_err0 !== e) begin
                        fails++;
                        $display("FAIL u0_count_err: got %0b expected %0b", count_err0, e);
                    end
                end
            end else if (count_err0) begin
                tests++; fails++;
                $display("FAIL u0_count_err_alone: got 1 expected 0 outside latched");
            end
            if (latched1) begin
                tests++;
                if (exp_q1.size() == 0) begin
                    fails++;
                    $display("FAIL u1_latched_unexpected: latched=1 count_err=%0b, no latch expected", count_err1);
                end else begin
                    logic [0:0] e;
                    e = exp_q1.pop_front();
                    if (count_err1 !== e) begin
                        fails++;
                        $display("FAIL u1_count_err: got %0b expected %0b", count_err1, e);
                    end
                end
            end else if (count_err1) begin
                tests++; fails++;
                $display("FAIL u1_count_err_alone: got 1 expected 0 outside latched");
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // driver: one serial bit, sin stable across the sclk rise
    task automatic send_bit(input logic b);
        sin = b;
        wait_cyc(2);
        sclk = 1'b1;
        wait_cyc(3);
        sclk = 1'b0;
        wait_cyc(3);
    endtask

    task automatic send_bits(input logic [383:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_latch(input logic m, input logic exp_err);
        mode = m;
        wait_cyc(4);
        exp_q0.push_back(exp_err);
        exp_q1.push_back(exp_err);
        xlat = 1'b1;
        wait_cyc(4);
        xlat = 1'b0;
        wait_cyc(4);
    endtask

    task automatic gs_pulse();
        gsclk = 1'b1;
        wait_cyc(3);
        gsclk = 1'b0;
        wait_cyc(3);
    endtask

    function automatic logic [191:0] gs_frame(input logic [11:0] ch [16]);
        logic [191:0] f;
        for (int n = 0; n < 16; n++) f[n*12 +: 12] = ch[n];
        return f;
    endfunction

    task automatic check_gs(input string name, input bit dev1, input int ch, input logic [11:0] exp);
        rd_ch = 4'(ch);
        #1;
        check(name, dev1 ? {20'h0, rd_gs1} : {20'h0, rd_gs0}, {20'h0, exp});
    endtask

    task automatic check_dc(input string name, input bit dev1, input int ch, input logic [5:0] exp);
        rd_ch = 4'(ch);
        #1;
        check(name, dev1 ? {26'h0, rd_dc1} : {26'h0, rd_dc0}, {26'h0, exp});
    endtask

    logic [11:0]  chv [16];
    logic [191:0] fa, fb, fr;
    logic [95:0]  fdc;

    initial begin
        // reset state
        wait_cyc(3);
        check("reset_sout", {31'h0, sout0}, 32'h0);
        check("reset_pwm", {16'h0, pwm0}, 32'h0);
        check("reset_latched", {31'h0, latched0}, 32'h0);
        check_gs("reset_gs15", 0, 15, 12'h000);
        check_dc("reset_dc0", 0, 0, 6'h00);
        reset = 1'b0;
        wait_cyc(5);

        // GS frame: ch15=FFF, ch0=001
        for (int n = 0; n < 16; n++) chv[n] = 12'h000;
        chv[15] = 12'hFFF; chv[0] = 12'h001;
        fr = gs_frame(chv);
        send_bits({192'h0, fr}, 192);
        do_latch(1'b0, 1'b0);
        check_gs("gs1_ch15", 0, 15, 12'hFFF);
        check_gs("gs1_ch0", 0, 0, 12'h001);
        check_gs("gs1_ch7", 0, 7, 12'h000);

        // DC frame: all channels 0x2A
        for (int n = 0; n < 16; n++) fdc[n*6 +: 6] = 6'h2A;
        mode = 1'b1;
        wait_cyc(4);
        send_bits({288'h0, fdc}, 96);
        do_latch(1'b1, 1'b0);
        check_dc("dc_ch0", 0, 0, 6'h2A);
        check_dc("dc_ch9", 0, 9, 6'h2A);
        check_dc("dc_ch15", 0, 15, 6'h2A);
        check_gs("dc_keeps_gs15", 0, 15, 12'hFFF);
        mode = 1'b0;
        wait_cyc(4);

        // short GS frame, then a correct one with ch3=5
        send_bits({192'h0, fr}, 191);
        do_latch(1'b0, 1'b1);
        for (int n = 0; n < 16; n++) chv[n] = 12'h000;
        chv[3] = 12'h005;
        fr = gs_frame(chv);
        send_bits({192'h0, fr}, 192);
        do_latch(1'b0, 1'b0);
        check_gs("gs2_ch3", 0, 3, 12'h005);
        check_gs("gs2_ch15", 0, 15, 12'h000);

        // PWM on ch3=5
        blank = 1'b0;
        wait_cyc(5);
        check("pwm_cnt0", {16'h0, pwm0}, 32'h0008);
        for (int k = 1; k <= 10; k++) begin
            gs_pulse();
            check($sformatf("pwm_cnt%0d", k), {16'h0, pwm0}, (k < 5) ? 32'h0008 : 32'h0000);
        end
        blank = 1'b1;
        wait_cyc(5);
        check("pwm_blank", {16'h0, pwm0}, 32'h0);
        blank = 1'b0;
        wait_cyc(5);
        check("pwm_cnt_cleared", {16'h0, pwm0}, 32'h0008);
        blank = 1'b1;
        wait_cyc(5);

        // ch0=FFF, run the counter past saturation
        for (int n = 0; n < 16; n++) chv[n] = 12'h000;
        chv[0] = 12'hFFF;
        fr = gs_frame(chv);
        send_bits({192'h0, fr}, 192);
        do_latch(1'b0, 1'b0);
        blank = 1'b0;
        wait_cyc(5);
        check("sat_cnt0", {16'h0, pwm0}, 32'h0001);
        for (int k = 1; k <= 4200; k++) begin
            gs_pulse();
            if (k == 4094) check("sat_cnt4094", {16'h0, pwm0}, 32'h0001);
            if (k == 4095) check("sat_cnt4095", {16'h0, pwm0}, 32'h0000);
            if (k == 4200) check("sat_cnt4200", {16'h0, pwm0}, 32'h0000);
        end
        blank = 1'b1;
        wait_cyc(5);

        // daisy chain: 384 bits, device 1 holds the first 192
        for (int n = 0; n < 16; n++) chv[n] = {4'(n), 8'hA5};
        fa = gs_frame(chv);
        for (int n = 0; n < 16; n++) chv[n] = 12'h8C0 | 12'(n);
        fb = gs_frame(chv);
        send_bits({fa, fb}, 384);
        do_latch(1'b0, 1'b1);
        check_gs("chain_u1_ch0", 1, 0, fa[11:0]);
        check_gs("chain_u1_ch15", 1, 15, fa[191:180]);
        check_gs("chain_u0_ch0", 0, 0, fb[11:0]);
        check_gs("chain_u0_ch15", 0, 15, fb[191:180]);

        // 100 more bits, then reset mid-frame
        send_bits({384{1'b1}}, 100);
        check("chain_sout0", {31'h0, sout0}, {31'h0, fb[91]});
        check("chain_sout1", {31'h0, sout1}, {31'h0, fa[91]});
        reset = 1'b1;
        wait_cyc(3);
        check("rst_sout0", {31'h0, sout0}, 32'h0);
        check("rst_sout1", {31'h0, sout1}, 32'h0);
        check_gs("rst_u0_gs0", 0, 0, 12'h000);
        check_gs("rst_u1_gs15", 1, 15, 12'h000);
        check_dc("rst_u0_dc5", 0, 5, 6'h00);
        reset = 1'b0;
        wait_cyc(10);
        check("rst_no_latch", {31'h0, latched0}, 32'h0);

        check("exp_q0_drained", exp_q0.size(), 32'h0);
        check("exp_q1_drained", exp_q1.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
